// File: rtl/isam_core_p.sv
`timescale 1ns/1ps
// isam_core_p: ISAM execution core, one 32-bit command per accepted beat over a
// REG_N x DATA_W register file, with an iterative multiplier and a HALT state.
// Ports:
//   sys_clk, sys_rst_n      clock, async active-low reset
//   cmd/cmd_valid/cmd_ready command beat in {rb/imm, ra/imm, rd, op}
//   cmd_id                  index of the next command to fetch
//   res/res_valid/res_ready one-entry result buffer filled by OUT
//   halted                  core is in HALT
module isam_core_p #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 16,
  parameter int unsigned PC_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [31:0]       cmd,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [PC_W-1:0]   cmd_id,
  output logic [DATA_W-1:0] res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              halted
);

  localparam int unsigned IDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  localparam logic [7:0] OP_JMP  = 8'd1;
  localparam logic [7:0] OP_WH   = 8'd2;
  localparam logic [7:0] OP_WL   = 8'd3;
  localparam logic [7:0] OP_MOV  = 8'd4;
  localparam logic [7:0] OP_RST  = 8'd5;
  localparam logic [7:0] OP_IFEQ = 8'd6;
  localparam logic [7:0] OP_IFNE = 8'd7;
  localparam logic [7:0] OP_IFGE = 8'd8;
  localparam logic [7:0] OP_IFLE = 8'd9;
  localparam logic [7:0] OP_ADD  = 8'd10;
  localparam logic [7:0] OP_SUB  = 8'd11;
  localparam logic [7:0] OP_NOT  = 8'd12;
  localparam logic [7:0] OP_OR   = 8'd13;
  localparam logic [7:0] OP_AND  = 8'd14;
  localparam logic [7:0] OP_XOR  = 8'd15;
  localparam logic [7:0] OP_SL   = 8'd16;
  localparam logic [7:0] OP_SR   = 8'd17;
  localparam logic [7:0] OP_OUT  = 8'd18;
  localparam logic [7:0] OP_MUL  = 8'd19;
  localparam logic [7:0] OP_HALT = 8'd20;

  typedef enum logic [1:0] {ST_RUN, ST_MUL, ST_HALT} state_t;

  state_t             state;
  logic [DATA_W-1:0]  rf [REG_N];
  logic [DATA_W-1:0]  mul_a;
  logic [DATA_W-1:0]  mul_b;
  logic [DATA_W-1:0]  mul_acc;
  logic [CNT_W-1:0]   mul_cnt;
  logic [7:0]         mul_rd;

  logic               accept;
  logic [7:0]         op, f_rd, f_ra, f_rb;
  logic [15:0]        imm16;
  logic [DATA_W-1:0]  rd_v, ra_v, rb_v;
  logic [DATA_W-1:0]  acc_nxt;
  logic               mul_last;
  logic [PC_W-1:0]    pc_nxt;
  logic               wr_en;
  logic [7:0]         wr_idx;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_ok;

  assign cmd_ready = (state == ST_RUN) && (!res_valid || res_ready);
  assign accept    = cmd_valid && cmd_ready;

  // Field split and register reads; out-of-range indices read as zero.
  always_comb begin
    op    = cmd[7:0];
    f_rd  = cmd[15:8];
    f_ra  = cmd[23:16];
    f_rb  = cmd[31:24];
    imm16 = cmd[31:16];
    rd_v  = (32'(f_rd) < REG_N) ? rf[f_rd[IDX_W-1:0]] : '0;
    ra_v  = (32'(f_ra) < REG_N) ? rf[f_ra[IDX_W-1:0]] : '0;
    rb_v  = (32'(f_rb) < REG_N) ? rf[f_rb[IDX_W-1:0]] : '0;
  end

  // One shift-add step of the multiplier; the final step writes the product.
  assign acc_nxt  = mul_acc + (mul_b[0] ? mul_a : '0);
  assign mul_last = (mul_cnt == CNT_W'(DATA_W - 1));

  // Command decode: next pc and the single register-file write port.
  always_comb begin
    pc_nxt  = cmd_id + PC_W'(1);
    wr_en   = 1'b0;
    wr_idx  = f_rd;
    wr_data = '0;
    case (op)
      OP_JMP:  pc_nxt = cmd[8 +: PC_W];
      OP_WH:   begin wr_en = 1'b1; wr_data = {imm16, rd_v[DATA_W-17:0]}; end
      OP_WL:   begin wr_en = 1'b1; wr_data = {rd_v[DATA_W-1:16], imm16}; end
      OP_MOV:  begin wr_en = 1'b1; wr_data = ra_v; end
      OP_RST:  begin wr_en = 1'b1; wr_data = '0; end
      OP_IFEQ: if (rd_v == ra_v) pc_nxt = cmd_id + PC_W'(2);
      OP_IFNE: if (rd_v != ra_v) pc_nxt = cmd_id + PC_W'(2);
      OP_IFGE: if (rd_v >= ra_v) pc_nxt = cmd_id + PC_W'(2);
      OP_IFLE: if (rd_v <= ra_v) pc_nxt = cmd_id + PC_W'(2);
      OP_ADD:  begin wr_en = 1'b1; wr_data = ra_v + rb_v; end
      OP_SUB:  begin wr_en = 1'b1; wr_data = ra_v - rb_v; end
      OP_NOT:  begin wr_en = 1'b1; wr_data = ~ra_v; end
      OP_OR:   begin wr_en = 1'b1; wr_data = ra_v | rb_v; end
      OP_AND:  begin wr_en = 1'b1; wr_data = ra_v & rb_v; end
      OP_XOR:  begin wr_en = 1'b1; wr_data = ra_v ^ rb_v; end
      OP_SL:   begin
        wr_en   = 1'b1;
        wr_data = (rb_v >= DATA_W'(DATA_W)) ? '0 : (ra_v << rb_v);
      end
      OP_SR:   begin
        wr_en   = 1'b1;
        wr_data = (rb_v >= DATA_W'(DATA_W)) ? '0 : (ra_v >> rb_v);
      end
      default: ;
    endcase
    wr_en = wr_en && accept;
    if (state == ST_MUL && mul_last) begin
      wr_en   = 1'b1;
      wr_idx  = mul_rd;
      wr_data = acc_nxt;
    end
  end

  // Writes to indices beyond the register file are silently dropped.
  assign wr_ok = wr_en && (32'(wr_idx) < REG_N);

  // State register, register file, result buffer and multiplier datapath.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_RUN;
      cmd_id    <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      halted    <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_acc   <= '0;
      mul_cnt   <= '0;
      mul_rd    <= '0;
      for (int i = 0; i < int'(REG_N); i++) rf[i] <= '0;
    end else begin
      if (wr_ok) rf[wr_idx[IDX_W-1:0]] <= wr_data;

      // OUT reloads the buffer even on a pop edge; otherwise a pop just clears valid.
      if (accept && op == OP_OUT) begin
        res       <= rd_v;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      case (state)
        ST_RUN: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state   <= ST_MUL;
              mul_a   <= ra_v;
              mul_b   <= rb_v;
              mul_acc <= '0;
              mul_cnt <= '0;
              mul_rd  <= f_rd;
            end else if (op == OP_HALT) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              cmd_id <= pc_nxt;
            end
          end
        end
        ST_MUL: begin
          mul_acc <= acc_nxt;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + CNT_W'(1);
          if (mul_last) begin
            state  <= ST_RUN;
            cmd_id <= cmd_id + PC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_isam_core_p.sv
`timescale 1ns/1ps
// tb_isam_core_p: directed-vector bench for isam_core_p with hand-computed results.
module tb_isam_core_p;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_id;
  logic [31:0] res;
  logic        res_valid;
  logic        res_ready;
  logic        halted;

  int errors = 0;
  int checks = 0;

  isam_core_p #(.DATA_W(32), .REG_N(16), .PC_W(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .res       (res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .halted    (halted)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] rd,
                                      input logic [7:0] ra, input logic [7:0] rb);
    return {rb, ra, rd, op};
  endfunction

  function automatic logic [31:0] imm(input logic [7:0] op, input logic [7:0] rd,
                                      input logic [15:0] v);
    return {v, rd, op};
  endfunction

  // Present a command, wait (bounded) for ready, and return #1 after the accept edge.
  task automatic send(input logic [31:0] c);
    int n = 0;
    cmd       = c;
    cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 100) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (!cmd_ready) check("ready_timeout", cmd_ready, 1);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic out_chk(input string tag, input logic [7:0] r, input logic [31:0] exp);
    send(enc(8'd18, r, 8'd0, 8'd0));
    check(tag, res, exp);
  endtask

  task automatic rst_pulse();
    sys_rst_n = 1'b0;
    #2;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  initial begin
    int lo;
    sys_rst_n = 1'b0;
    cmd       = '0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    #12;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Reset state
    check("rst_cmd_id", cmd_id, 0);
    check("rst_res", res, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    // 1: WL/WL/ADD/OUT
    send(imm(8'd3, 8'd1, 16'd5));
    send(imm(8'd3, 8'd2, 16'd7));
    send(enc(8'd10, 8'd3, 8'd1, 8'd2));
    send(enc(8'd18, 8'd3, 8'd0, 8'd0));
    check("add_res", res, 12);
    check("add_res_valid", res_valid, 1);
    check("add_cmd_id", cmd_id, 4);

    // 2: back-pressure on the result buffer
    send(imm(8'd3, 8'd5, 16'd1));
    send(imm(8'd3, 8'd6, 16'd2));
    res_ready = 1'b0;
    send(enc(8'd18, 8'd5, 8'd0, 8'd0));
    check("bp_res1", res, 1);
    check("bp_id1", cmd_id, 7);
    cmd       = enc(8'd18, 8'd6, 8'd0, 8'd0);
    cmd_valid = 1'b1;
    #1;
    check("bp_ready_low", cmd_ready, 0);
    repeat (3) begin @(posedge sys_clk); #1; end
    check("bp_res_hold", res, 1);
    check("bp_valid_hold", res_valid, 1);
    check("bp_id_hold", cmd_id, 7);
    res_ready = 1'b1;
    #1;
    check("bp_ready_high", cmd_ready, 1);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    check("bp_res2", res, 2);
    check("bp_valid2", res_valid, 1);
    check("bp_id2", cmd_id, 8);
    @(posedge sys_clk); #1;
    check("pop_valid", res_valid, 0);
    check("pop_res_keep", res, 2);

    // 3: iterative multiply
    send(imm(8'd3, 8'd1, 16'h0003));
    send(imm(8'd2, 8'd1, 16'h0001));
    send(imm(8'd3, 8'd2, 16'h0005));
    send(enc(8'd19, 8'd4, 8'd1, 8'd2));
    check("mul_id_hold", cmd_id, 11);
    lo = 0;
    for (int i = 0; i < 32; i++) begin
      if (!cmd_ready) lo++;
      @(posedge sys_clk); #1;
    end
    check("mul_busy_cycles", lo, 32);
    check("mul_ready_after", cmd_ready, 1);
    check("mul_id_after", cmd_id, 12);
    out_chk("mul_r4", 8'd4, 32'h0005_000F);
    send(enc(8'd19, 8'd1, 8'd1, 8'd1));
    out_chk("mul_alias_r1", 8'd1, 32'h0006_0009);
    check("mul_id_end", cmd_id, 15);

    // 4: pc wrap, skip and jump
    send(32'h00FF_FF01);
    check("jmp_ffff", cmd_id, 16'hFFFF);
    send(32'h0000_0000);
    check("pass_wrap", cmd_id, 16'h0000);
    send(32'h00FF_FF01);
    send(enc(8'd6, 8'd7, 8'd8, 8'd0));
    check("ifeq_wrap", cmd_id, 16'h0001);
    send(32'h0012_3401);
    check("jmp_1234", cmd_id, 16'h1234);
    send(enc(8'd7, 8'd7, 8'd8, 8'd0));
    check("ifne_false", cmd_id, 16'h1235);

    // 5: shifts, out-of-range register, wrap-around arithmetic
    send(imm(8'd3, 8'd9, 16'd32));
    send(enc(8'd16, 8'd10, 8'd1, 8'd9));
    out_chk("sl_32", 8'd10, 32'h0);
    send(imm(8'd2, 8'd11, 16'h8000));
    send(imm(8'd3, 8'd12, 16'd31));
    send(enc(8'd17, 8'd13, 8'd11, 8'd12));
    out_chk("sr_31", 8'd13, 32'h1);
    send(imm(8'd2, 8'd20, 16'hABCD));
    out_chk("oob_read", 8'd20, 32'h0);
    out_chk("oob_no_alias", 8'd4, 32'h0005_000F);
    send(enc(8'd11, 8'd14, 8'd7, 8'd5));
    out_chk("sub_wrap", 8'd14, 32'hFFFF_FFFF);
    send(enc(8'd15, 8'd15, 8'd1, 8'd2));
    out_chk("xor", 8'd15, 32'h0006_000C);
    check("id_pre_halt", cmd_id, 16'h1243);

    // 6: HALT and reset recovery
    send(enc(8'd20, 8'd0, 8'd0, 8'd0));
    check("halt_flag", halted, 1);
    check("halt_ready", cmd_ready, 0);
    cmd       = enc(8'd0, 8'd0, 8'd0, 8'd0);
    cmd_valid = 1'b1;
    repeat (3) begin @(posedge sys_clk); #1; end
    cmd_valid = 1'b0;
    check("halt_id_frozen", cmd_id, 16'h1243);
    rst_pulse();
    check("hrst_halted", halted, 0);
    check("hrst_id", cmd_id, 0);
    check("hrst_res", res, 0);
    check("hrst_ready", cmd_ready, 1);
    out_chk("hrst_r3", 8'd3, 32'h0);

    send(imm(8'd3, 8'd1, 16'd3));
    out_chk("pre_mul_out", 8'd1, 32'd3);
    send(enc(8'd19, 8'd1, 8'd1, 8'd1));
    repeat (5) begin @(posedge sys_clk); #1; end
    check("mid_mul_busy", cmd_ready, 0);
    rst_pulse();
    check("mrst_ready", cmd_ready, 1);
    check("mrst_id", cmd_id, 0);
    check("mrst_res", res, 0);
    check("mrst_valid", res_valid, 0);
    repeat (40) begin @(posedge sys_clk); #1; end
    check("mrst_id_stable", cmd_id, 0);
    out_chk("mrst_r1", 8'd1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
